// File: rtl/to_fp8_con_ctrl_pkg.sv
// Shared constants for the FP4/FP8/FP16 -> FP9 conversion controller:
// operand type codes, bus widths and FSM state encodings.
package to_fp8_con_ctrl_pkg;

  // Operand bus and element widths
  localparam int MATRIX_BUS_WIDTH = 32;
  localparam int EL_WIDTH         = 9;
  localparam int OUT_WIDTH        = 4 * EL_WIDTH;
  localparam int CONV_WIDTH       = 8 * EL_WIDTH;

  // Operand type codes carried on type_ab
  localparam logic [4:0] FP4  = 5'd1;
  localparam logic [4:0] FP8  = 5'd2;
  localparam logic [4:0] FP16 = 5'd3;

  // FP8 subtype codes carried on type_ab_sub
  localparam logic [2:0] FP8E4M3 = 3'd0;
  localparam logic [2:0] FP8E5M2 = 3'd1;

  // Controller states. The mode of an open group is implied by the state:
  // S_FP4_HI owes the upper FP4 beat, S_FP16_H1 holds the first FP16 half.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FP4_HI  = 2'd1,
    S_FP16_H1 = 2'd2
  } state_e;

  // True for the FP8 subtypes the converter understands
  function automatic logic fp8_sub_ok(input logic [2:0] sub);
    return (sub == FP8E4M3) || (sub == FP8E5M2);
  endfunction

endpackage

// File: rtl/to_fp8_con_ctrl_out_reg.sv
// Valid/ready output register: a load replaces the beat (even while one is
// leaving), the beat holds while the consumer stalls, clear drops valid.
module to_fp8_out_reg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Valid flag: clear wins, a load sets it, a leaving beat with no load drops it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data register: only written on a load, otherwise holds its value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (!clear && load) begin
      out_data <= load_data;
    end
  end

endmodule

// File: rtl/to_fp8_con_ctrl.sv
// Sequencing controller for the FP4/FP8/FP16 -> FP9 (E5M3) conversion path.
// Input words are handed to an external combinational converter; its result
// is packed into 36-bit beats of four 9-bit elements.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds valid and data until the
// transfer; ready here never depends on valid. out_data_o is stable while
// out_valid_o=1 and out_ready_i=0.
module to_fp8_con_ctrl
  import to_fp8_con_ctrl_pkg::*;
#(
  parameter int IN_W  = MATRIX_BUS_WIDTH,
  parameter int EL_W  = EL_WIDTH,
  parameter int OUT_W = 4 * EL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          type_ab,
  input  logic [2:0]          type_ab_sub,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_W-1:0]     in_data_i,
  output logic [IN_W-1:0]     conv_data_o,
  input  logic [8*EL_W-1:0]   conv_res_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_W-1:0]    out_data_o,
  output logic                err_o
);

  state_e             state_q;
  state_e             state_d;
  logic [OUT_W-1:0]   hi_buf;
  logic [2*EL_W-1:0]  half_buf;
  logic               err_q;

  logic               accept;
  logic               beat_leave;
  logic               is_fp4;
  logic               is_fp8_ok;
  logic               is_fp16;
  logic               out_load;
  logic [OUT_W-1:0]   out_load_data;
  logic               hi_ld;
  logic               half_ld;
  logic               err_d;

  // The converter sees the input word directly
  assign conv_data_o = in_data_i;

  // Type decode of the word currently presented
  assign is_fp4    = (type_ab == FP4);
  assign is_fp8_ok = (type_ab == FP8) && fp8_sub_ok(type_ab_sub);
  assign is_fp16   = (type_ab == FP16);

  // Ready: not while the upper FP4 beat is owed, not while flushing, and only
  // when the output register is free or being emptied this cycle
  assign in_ready_o = !flush_i && (state_q != S_FP4_HI) &&
                      (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign beat_leave = out_valid_o && out_ready_i;
  assign err_o      = err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush returns to idle and abandons any open group
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_fp4) begin
            state_d = S_FP4_HI;
          end else if (accept && is_fp16) begin
            state_d = S_FP16_H1;
          end
        end
        S_FP4_HI: begin
          if (beat_leave) begin
            state_d = S_IDLE;
          end
        end
        S_FP16_H1: begin
          if (accept) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: output-register loads, buffer captures and the drop flag
  always_comb begin
    out_load      = 1'b0;
    out_load_data = '0;
    hi_ld         = 1'b0;
    half_ld       = 1'b0;
    err_d         = 1'b0;
    if (!flush_i) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_fp4) begin
              out_load      = 1'b1;
              out_load_data = conv_res_i[OUT_W-1:0];
              hi_ld         = 1'b1;
            end else if (is_fp8_ok) begin
              out_load      = 1'b1;
              out_load_data = conv_res_i[OUT_W-1:0];
            end else if (is_fp16) begin
              half_ld       = 1'b1;
            end else begin
              err_d         = 1'b1;
            end
          end
        end
        S_FP4_HI: begin
          if (beat_leave) begin
            out_load      = 1'b1;
            out_load_data = hi_buf;
          end
        end
        S_FP16_H1: begin
          // Second FP16 word: its type is ignored, the open group decides
          if (accept) begin
            out_load      = 1'b1;
            out_load_data = {conv_res_i[2*EL_W-1:0], half_buf};
          end
        end
        default: ;
      endcase
    end
  end

  // Group buffers and the registered drop pulse; flush leaves buffers alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_buf   <= '0;
      half_buf <= '0;
      err_q    <= 1'b0;
    end else begin
      if (hi_ld) begin
        hi_buf <= conv_res_i[8*EL_W-1:OUT_W];
      end
      if (half_ld) begin
        half_buf <= conv_res_i[2*EL_W-1:0];
      end
      err_q <= err_d;
    end
  end

  to_fp8_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .load      (out_load),
    .load_data (out_load_data),
    .out_ready (out_ready_i),
    .out_valid (out_valid_o),
    .out_data  (out_data_o)
  );

endmodule

// File: tb/tb_to_fp8_con_ctrl.sv
// Bench for to_fp8_con_ctrl: converter result is stubbed by the bench,
// expected beats go into a queue and are checked as they leave the DUT.
module tb_to_fp8_con_ctrl;
  import to_fp8_con_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  type_ab;
  logic [2:0]  type_ab_sub;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [31:0] conv_data_o;
  logic [71:0] conv_res_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [35:0] out_data_o;
  logic        err_o;

  logic [35:0] exp_q[$];
  int          total;
  int          bad;

  to_fp8_con_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .type_ab     (type_ab),
    .type_ab_sub (type_ab_sub),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .conv_data_o (conv_data_o),
    .conv_res_i  (conv_res_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .err_o       (err_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every beat that leaves must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected got=%h want=none", out_data_o);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          bad++;
          $display("FAIL beat_data got=%h want=%h", out_data_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] rand_res();
    logic [71:0] r;
    r[71:40] = $urandom();
    r[39:8]  = $urandom();
    r[7:0]   = 8'($urandom_range(255, 0));
    return r;
  endfunction

  task automatic drive_word(input logic [4:0] t, input logic [2:0] s,
                            input logic [31:0] d, input logic [71:0] r);
    in_valid_i  = 1'b1;
    type_ab     = t;
    type_ab_sub = s;
    in_data_i   = d;
    conv_res_i  = r;
  endtask

  task automatic idle_in();
    in_valid_i = 1'b0;
    type_ab    = 5'h00;
    conv_res_i = rand_res();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    type_ab_sub = 3'd0;
    in_data_i = 32'h0;
    idle_in();
    #3;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(S_IDLE));
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fp8_stream();
    logic [35:0] v[3];
    logic [71:0] r;
    v[0] = 36'h00000001C;
    v[1] = 36'h0000000A5;
    v[2] = 36'h123456789;
    for (int i = 0; i < 3; i++) begin
      r = rand_res();
      r[35:0] = v[i];
      drive_word(FP8, FP8E4M3, $urandom(), r);
      #1;
      chk("fp8_in_ready", 64'(in_ready_o), 64'd1);
      chk("fp8_conv_data", 64'(conv_data_o), 64'(in_data_i));
      exp_q.push_back(v[i]);
      tick();
      chk("fp8_latency_valid", 64'(out_valid_o), 64'd1);
      chk("fp8_latency_data", 64'(out_data_o), 64'(v[i]));
    end
    idle_in();
    tick();
    chk("fp8_drain_valid", 64'(out_valid_o), 64'd0);
  endtask

  task automatic test_fp4_split();
    drive_word(FP4, 3'd0, 32'h76543210, {36'h123456789, 36'h0ABCDEF01});
    #1;
    chk("fp4_conv_data", 64'(conv_data_o), 64'h76543210);
    exp_q.push_back(36'h0ABCDEF01);
    exp_q.push_back(36'h123456789);
    tick();
    idle_in();
    #1;
    chk("fp4_beat0", 64'(out_data_o), 64'h0ABCDEF01);
    chk("fp4_in_ready_low", 64'(in_ready_o), 64'd0);
    chk("fp4_state_hi", 64'(dut.state_q), 64'(S_FP4_HI));
    tick();
    chk("fp4_beat1", 64'(out_data_o), 64'h123456789);
    chk("fp4_beat1_valid", 64'(out_valid_o), 64'd1);
    chk("fp4_in_ready_back", 64'(in_ready_o), 64'd1);
    tick();
    chk("fp4_drain_valid", 64'(out_valid_o), 64'd0);
  endtask

  task automatic fp16_pair(input string name, input logic [17:0] h0, input logic [17:0] h1);
    logic [71:0] r;
    r = rand_res();
    r[17:0] = h0;
    drive_word(FP16, 3'd0, $urandom(), r);
    tick();
    idle_in();
    chk({name, "_no_beat_after_first"}, 64'(out_valid_o), 64'd0);
    tick();
    r = rand_res();
    r[17:0] = h1;
    // Second word carries FP8 type; the open FP16 group must win
    drive_word(FP8, FP8E4M3, $urandom(), r);
    exp_q.push_back({h1, h0});
    tick();
    idle_in();
    chk({name, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({name, "_data"}, 64'(out_data_o), 64'({h1, h0}));
    tick();
    chk({name, "_drain"}, 64'(out_valid_o), 64'd0);
  endtask

  task automatic test_fp16_pair();
    fp16_pair("fp16", 18'h12345, 18'h0ABCD);
    chk("fp16_packed_const", 64'(dut.out_data_o), 64'h2AF352345);
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive_word(FP4, 3'd0, 32'hCAFEF00D, {36'h9876543AB, 36'h0DEADBEEF});
    exp_q.push_back(36'h0DEADBEEF);
    exp_q.push_back(36'h9876543AB);
    tick();
    // Keep an FP8 word offered during the stall: it must not be taken
    drive_word(FP8, FP8E5M2, 32'h11111111, rand_res());
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", 64'(out_valid_o), 64'd1);
      chk("bp_hold_data", 64'(out_data_o), 64'h0DEADBEEF);
      chk("bp_in_ready", 64'(in_ready_o), 64'd0);
      tick();
    end
    idle_in();
    out_ready_i = 1'b1;
    tick();
    chk("bp_beat1_next", 64'(out_data_o), 64'h9876543AB);
    chk("bp_beat1_valid", 64'(out_valid_o), 64'd1);
    tick();
    chk("bp_drain", 64'(out_valid_o), 64'd0);
  endtask

  task automatic test_unsupported();
    drive_word(5'h1F, 3'd0, $urandom(), rand_res());
    tick();
    idle_in();
    chk("err_type_pulse", 64'(err_o), 64'd1);
    chk("err_type_no_out", 64'(out_valid_o), 64'd0);
    chk("err_type_state", 64'(dut.state_q), 64'(S_IDLE));
    tick();
    chk("err_type_one_cycle", 64'(err_o), 64'd0);
    drive_word(FP8, 3'd5, $urandom(), rand_res());
    tick();
    idle_in();
    chk("err_sub_pulse", 64'(err_o), 64'd1);
    chk("err_sub_no_out", 64'(out_valid_o), 64'd0);
    chk("err_sub_state", 64'(dut.state_q), 64'(S_IDLE));
    tick();
    chk("err_sub_one_cycle", 64'(err_o), 64'd0);
  endtask

  task automatic test_abort_flush();
    logic [71:0] r;
    r = rand_res();
    r[17:0] = 18'h3FFFF;
    drive_word(FP16, 3'd0, $urandom(), r);
    tick();
    flush_i = 1'b1;
    drive_word(FP16, 3'd0, $urandom(), rand_res());
    #1;
    chk("flush_in_ready", 64'(in_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    idle_in();
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_state", 64'(dut.state_q), 64'(S_IDLE));
    tick();
    fp16_pair("flush_pair", 18'h01F2E, 18'h2C3D4);
  endtask

  task automatic test_abort_reset();
    logic [71:0] r;
    r = rand_res();
    r[17:0] = 18'h15555;
    drive_word(FP16, 3'd0, $urandom(), r);
    tick();
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(out_valid_o), 64'd0);
    chk("areset_state", 64'(dut.state_q), 64'(S_IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("areset_no_output", 64'(out_valid_o), 64'd0);
    fp16_pair("areset_pair", 18'h0A0A0, 18'h30303);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fp8_stream();
    test_fp4_split();
    test_fp16_pair();
    test_backpressure();
    test_unsupported();
    test_abort_flush();
    test_abort_reset();
    tick();
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/to_fp8_con_ctrl.md
Name: to_fp8_con_ctrl

Overview:
Sequencing controller for the FP4/FP8/FP16 → FP9 (E5M3 container, 9-bit) conversion datapath in the tensor-core operand path.
- Accepts 32-bit packed operand words over valid/ready.
- Drives the combinational converter and receives its result.
- Emits 36-bit beats of four 9-bit elements over valid/ready.
- Beats per word:
  - FP4 word (8 elements): two output beats.
  - FP8 word (4 elements): one output beat.
  - FP16 word (2 elements): buffered; two input words produce one output beat.

Parameters:
IN_W, 32, input word width (`MATRIX_BUS_WIDTH).
EL_W, 9, converted element width.
OUT_W, 36, output beat width (4*EL_W).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
type_ab  in  5  operand type (`FP4/`FP8/`FP16); sampled at accept.
type_ab_sub  in  3  FP8 subtype (`FP8E4M3/`FP8E5M2); sampled at accept.
flush_i  in  1  synchronous clear of partial groups and the output register.
in_valid_i  in  1  input word valid.
in_ready_o  out  1  input word ready.
in_data_i  in  IN_W  packed input word.
conv_data_o  out  IN_W  word presented to converter (= in_data_i, combinational).
conv_res_i  in  8*EL_W  converter result; element i at [9i+:9]; same-cycle combinational.
out_valid_o  out  1  output beat valid (registered).
out_ready_i  in  1  output beat ready.
out_data_o  out  OUT_W  output beat (registered).
err_o  out  1  one-cycle pulse: unsupported type word dropped.

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, err_o=0, state=S_IDLE, hi_buf=0, half_buf=0.
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Beat leaves = out_valid_o & out_ready_i.
  - out_data_o holds while out_valid_o & !out_ready_i.
- in_ready_o = (state != S_FP4_HI) & (!out_valid_o | out_ready_i). Combinational; does not depend on in_valid_i.
- States:
  - S_IDLE, S_FP4_HI, S_FP16_H1.
  - Mode is latched on the accept that leaves S_IDLE and held until the group completes.
- S_IDLE, accept:
  - FP8 with E4M3 or E5M2: out_data_o ← conv_res_i[35:0], out_valid_o←1, stay in S_IDLE. Latency 1 cycle.
  - FP4: out_data_o ← conv_res_i[35:0], hi_buf ← conv_res_i[71:36], out_valid_o←1, go to S_FP4_HI.
  - FP16: half_buf ← conv_res_i[17:0], go to S_FP16_H1. The output register is not written.
  - Other type, or FP8 with another subtype: word dropped, err_o pulses, stay in S_IDLE.
- S_FP4_HI: when the current beat leaves, out_data_o ← hi_buf, out_valid_o←1, go to S_IDLE. The second beat is never earlier than 1 cycle after the first.
- S_FP16_H1, accept: out_data_o ← {conv_res_i[17:0], half_buf}, out_valid_o←1, go to S_IDLE. type_ab on the second word is ignored (latched mode wins).
- Output clears: a beat leaves with no new load that cycle → out_valid_o←0.
- Back-to-back: a beat leaving and a new load in the same cycle → out_valid_o stays 1, data replaced. FP8 sustains 1 word/cycle. FP4 sustains 1 word per 2 cycles.
- flush_i (priority below reset, above all else): state←S_IDLE, out_valid_o←0, buffers untouched. A word presented in the same cycle is not accepted (in_ready_o forced 0 while flush_i=1).
- Async reset mid-group: partial FP4 or FP16 data is discarded; no output after release until new input arrives.
- err_o is registered and is 1 only in the cycle after the dropped accept.

Decomposition:
- Type codes `FP4/`FP8/`FP16/`FP8E4M3/`FP8E5M2 and `MATRIX_BUS_WIDTH stay in the shared define.v.
- State encodings and the EL_W/OUT_W derivations go in the same shared define set as localparams/macros.
- Natural sub-module: to_fp8_out_reg (36-bit valid/ready output register with load and hold). FSM and buffers stay in the top module.

Test Plan:
- FP8 E4M3 stream: 3 back-to-back words, stub conv_res_i[35:0]=36'h00000001C/36'h0000000A5/36'h123456789, out_ready_i=1 → three beats in cycles 1,2,3 with those values; in_ready_o stays 1.
- FP4 split: in_data_i=32'h76543210, conv_res_i={36'h123456789,36'h0ABCDEF01} → beat 36'h0ABCDEF01 then 36'h123456789 on the next cycle; in_ready_o=0 for exactly one cycle.
- FP16 pair: word0 res[17:0]=18'h12345, word1 res[17:0]=18'h0ABCD → single beat 36'h2AF352345, one cycle after the second accept; no beat after the first.
- Backpressure: FP4 word with out_ready_i=0 for 5 cycles → beat0 held stable, in_ready_o=0, no input accepted; release → beat0 then beat1 in consecutive cycles.
- Unsupported type_ab=5'h1F, then FP8 with subtype not E4M3/E5M2 → err_o pulses one cycle each, no output, state stays S_IDLE.
- Mid-group abort: FP16 word0 accepted, then flush_i=1 (rerun with rst_n=0 asynchronously mid-cycle) → out_valid_o=0; the next FP16 pair yields exactly one correct beat and no stale half.
